uio_prbs_port: RTL and testbench



---
 rtl/uio_prbs_if.sv | 32 +++
 rtl/uio_prbs_port.sv | 228 ++++++++++++++++++++++
 tb/tb_uio_prbs_port.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uio_prbs_if.sv
// uio_prbs_if: request/response word channels between a PRBS port and the bbox.
// Ports: none; master = personality side (drives rq, rs_afull), slave = bbox side.
interface uio_prbs_if #(
   parameter int W = 128
) ();

   logic         uio_rq_vld;
   logic [W-1:0] uio_rq_data;
   logic         uio_rq_afull;
   logic         uio_rs_vld;
   logic [W-1:0] uio_rs_data;
   logic         uio_rs_afull;

   modport master (
      output uio_rq_vld,
      output uio_rq_data,
      output uio_rs_afull,
      input  uio_rq_afull,
      input  uio_rs_vld,
      input  uio_rs_data
   );

   modport slave (
      input  uio_rq_vld,
      input  uio_rq_data,
      input  uio_rs_afull,
      output uio_rq_afull,
      output uio_rs_vld,
      output uio_rs_data
   );

endinterface

// File: rtl/uio_prbs_port.sv
// uio_prbs_port: PRBS-31 traffic generator/checker for one user-IO port.
// Ports: clk_per/reset_per (sync, active-high), i_start/i_num_words run control,
//   o_busy/o_done/o_pass/o_timeout/o_*_cnt status, uio (rq out, rs in).
// Optional macro UIO_PRBS_ERR_INJECT_EN adds i_inject_err (bit-0 one-shot flip).
module uio_prbs_port #(
   parameter int          UIO_PORTS_WIDTH = 128,
   parameter logic [30:0] PRBS_SEED       = 31'h7FFFFFFF,
   parameter int          TIMEOUT_CYCLES  = 65535
) (
   input  logic        clk_per,
   input  logic        reset_per,
   input  logic        i_start,
   input  logic [31:0] i_num_words,
`ifdef UIO_PRBS_ERR_INJECT_EN
   input  logic        i_inject_err,
`endif
   output logic        o_busy,
   output logic        o_done,
   output logic        o_pass,
   output logic        o_timeout,
   output logic [31:0] o_err_cnt,
   output logic [31:0] o_tx_cnt,
   output logic [31:0] o_rx_cnt,
   uio_prbs_if.master  uio
);

   localparam int W = UIO_PORTS_WIDTH;
   localparam logic [30:0] SEED =
      (PRBS_SEED == 31'd0) ? 31'h7FFFFFFF : PRBS_SEED;
   localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   // One word = W Fibonacci steps; first step lands in bit 0.
   function automatic logic [W-1:0] prbs_word(input logic [30:0] s);
      logic [30:0]  t;
      logic [W-1:0] w;
      logic         n;
      t = s;
      w = '0;
      for (int i = 0; i < W; i++) begin
         n    = t[30] ^ t[27];
         t    = {t[29:0], n};
         w[i] = n;
      end
      return w;
   endfunction

   function automatic logic [30:0] prbs_next(input logic [30:0] s);
      logic [30:0] t;
      logic        n;
      t = s;
      for (int i = 0; i < W; i++) begin
         n = t[30] ^ t[27];
         t = {t[29:0], n};
      end
      return t;
   endfunction

   state_t       state_q, state_d;
   logic [31:0]  num_q, num_d;
   logic [31:0]  tx_q, tx_d;
   logic [31:0]  rx_q, rx_d;
   logic [31:0]  err_q, err_d;
   logic [31:0]  idle_q, idle_d;
   logic [30:0]  gen_q, gen_d;
   logic [30:0]  chk_q, chk_d;
   logic         rq_vld_q, rq_vld_d;
   logic [W-1:0] rq_data_q, rq_data_d;
   logic         done_q, done_d;
   logic         pass_q, pass_d;
   logic         timeout_q, timeout_d;
   logic [W-1:0] inj_mask;
   logic         active;
   logic         send;
   logic         rx_ok;

   assign active = (state_q == RUN) || (state_q == DRAIN);
   assign send   = (state_q == RUN) && !uio.uio_rq_afull
                   && (tx_q < num_q);
   // Words past num_words are dropped without counting.
   assign rx_ok  = active && uio.uio_rs_vld && (rx_q < num_q);

`ifdef UIO_PRBS_ERR_INJECT_EN
   logic inj_q, inj_d;

   assign inj_mask = {{(W-1){1'b0}}, inj_q};

   always_comb begin
      inj_d = inj_q;
      if (send)
         inj_d = 1'b0;
      if (i_inject_err)
         inj_d = 1'b1;
   end

   always_ff @(posedge clk_per) begin
      if (reset_per)
         inj_q <= 1'b0;
      else
         inj_q <= inj_d;
   end
`else
   assign inj_mask = '0;
`endif

   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      err_d     = err_q;
      idle_d    = idle_q;
      gen_d     = gen_q;
      chk_d     = chk_q;
      rq_vld_d  = 1'b0;
      rq_data_d = rq_data_q;
      done_d    = done_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               num_d     = i_num_words;
               tx_d      = '0;
               rx_d      = '0;
               err_d     = '0;
               idle_d    = '0;
               gen_d     = SEED;
               chk_d     = SEED;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               done_d    = 1'b0;
               if (i_num_words == 32'd0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN, DRAIN: begin
            if (send) begin
               rq_vld_d  = 1'b1;
               rq_data_d = prbs_word(gen_q) ^ inj_mask;
               gen_d     = prbs_next(gen_q);
               tx_d      = tx_q + 32'd1;
            end
            idle_d = '0;
            if (rx_ok) begin
               rx_d  = rx_q + 32'd1;
               chk_d = prbs_next(chk_q);
               if ((uio.uio_rs_data != prbs_word(chk_q))
                   && (err_q != '1))
                  err_d = err_q + 32'd1;
            end else if (state_q == DRAIN) begin
               idle_d = idle_q + 32'd1;
            end
            // Completion wins over timeout and covers an rx word
            // landing in the same cycle the last tx word goes out.
            if ((rx_d == num_q) && (tx_d == num_q)) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (err_d == 32'd0);
            end else if ((state_q == DRAIN) && (idle_d == TO)) begin
               state_d   = DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end else if (tx_d == num_q) begin
               state_d = DRAIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_per) begin
      if (reset_per) begin
         state_q   <= IDLE;
         num_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         err_q     <= '0;
         idle_q    <= '0;
         gen_q     <= SEED;
         chk_q     <= SEED;
         rq_vld_q  <= 1'b0;
         rq_data_q <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         err_q     <= err_d;
         idle_q    <= idle_d;
         gen_q     <= gen_d;
         chk_q     <= chk_d;
         rq_vld_q  <= rq_vld_d;
         rq_data_q <= rq_data_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_busy    = active;
   assign o_done    = done_q;
   assign o_pass    = pass_q;
   assign o_timeout = timeout_q;
   assign o_err_cnt = err_q;
   assign o_tx_cnt  = tx_q;
   assign o_rx_cnt  = rx_q;

   assign uio.uio_rq_vld   = rq_vld_q;
   assign uio.uio_rq_data  = rq_data_q;
   assign uio.uio_rs_afull = 1'b0;

endmodule

// File: tb/tb_uio_prbs_port.sv
// tb_uio_prbs_port: bench for uio_prbs_port with a 4-cycle loopback.
// Ports: none; scoreboard queue holds expected rq words per run.
module tb_uio_prbs_port;

   localparam int W  = 128;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        reset_per;
   logic        i_start;
   logic [31:0] i_num_words;
   logic        o_busy;
   logic        o_done;
   logic        o_pass;
   logic        o_timeout;
   logic [31:0] o_err_cnt;
   logic [31:0] o_tx_cnt;
   logic [31:0] o_rx_cnt;
`ifdef UIO_PRBS_ERR_INJECT_EN
   logic        i_inject_err;
   logic        inj_pending;
`endif

   uio_prbs_if #(.W(W)) uio ();

   uio_prbs_port #(
      .UIO_PORTS_WIDTH (W),
      .PRBS_SEED       (31'h7FFFFFFF),
      .TIMEOUT_CYCLES  (TO)
   ) u_dut (
      .clk_per     (clk),
      .reset_per   (reset_per),
      .i_start     (i_start),
      .i_num_words (i_num_words),
`ifdef UIO_PRBS_ERR_INJECT_EN
      .i_inject_err(i_inject_err),
`endif
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_pass      (o_pass),
      .o_timeout   (o_timeout),
      .o_err_cnt   (o_err_cnt),
      .o_tx_cnt    (o_tx_cnt),
      .o_rx_cnt    (o_rx_cnt),
      .uio         (uio.master)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int vld_seen = 0;
   int afull_viol = 0;
   logic afull_run = 1'b0;
   logic [W-1:0] exp_q[$];
   logic [30:0]  m_s;

   int flip_a = -1;
   int flip_b = -1;
   int drop_from = 1 << 30;

   // Loopback: 4-cycle delay, optional bit-77 flips and tail drop.
   int   rx_idx = 0;
   int   edge_cnt = 0;
   int   last_rx_edge = 0;
   logic afull_prev = 1'b0;
   logic         pv [3];
   logic [W-1:0] pd [3];

   always @(posedge clk) begin : lb
      logic         v;
      logic [W-1:0] d;
      edge_cnt = edge_cnt + 1;
      if (uio.uio_rs_vld === 1'b1)
         last_rx_edge = edge_cnt;
      afull_prev <= uio.uio_rq_afull;
      v = (uio.uio_rq_vld === 1'b1);
      d = uio.uio_rq_data;
      if (i_start === 1'b1)
         rx_idx = 0;
      else if (v) begin
         if (rx_idx == flip_a || rx_idx == flip_b)
            d[77] = ~d[77];
         if (rx_idx >= drop_from)
            v = 1'b0;
         rx_idx = rx_idx + 1;
      end
      if (reset_per) begin
         for (int i = 0; i < 3; i++) pv[i] <= 1'b0;
         uio.uio_rs_vld <= 1'b0;
      end else begin
         pv[0] <= v;
         pd[0] <= d;
         pv[1] <= pv[0];
         pd[1] <= pd[0];
         pv[2] <= pv[1];
         pd[2] <= pd[1];
         uio.uio_rs_vld <= pv[2];
      end
      uio.uio_rs_data <= pd[2];
   end

   task automatic gen_word(output logic [W-1:0] w);
      logic n;
      for (int i = 0; i < W; i++) begin
         n    = m_s[30] ^ m_s[27];
         m_s  = {m_s[29:0], n};
         w[i] = n;
      end
   endtask

   task automatic start_run(input int n);
      logic [W-1:0] w;
      m_s = 31'h7FFFFFFF;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         gen_word(w);
`ifdef UIO_PRBS_ERR_INJECT_EN
         if (inj_pending && i == 0) w[0] = ~w[0];
`endif
         exp_q.push_back(w);
      end
`ifdef UIO_PRBS_ERR_INJECT_EN
      inj_pending = 1'b0;
`endif
      @(negedge clk);
      i_num_words = n;
      i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (o_done === 1'b1) break;
         if (cyc >= limit) begin
            errors++;
            checks++;
            $display("FAIL done_wait cyc=%0d limit=%0d", cyc, limit);
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_per = 1'b1;
      i_start = 1'b0;
      i_num_words = '0;
      uio.uio_rq_afull = 1'b0;
`ifdef UIO_PRBS_ERR_INJECT_EN
      i_inject_err = 1'b0;
      inj_pending = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({o_busy, o_done, o_pass, o_timeout} !== 4'b0) begin
         errors++;
         $display("FAIL rst_flags got=%b exp=0000",
                  {o_busy, o_done, o_pass, o_timeout});
      end
      checks++;
      if ({o_err_cnt, o_tx_cnt, o_rx_cnt} !== 96'd0) begin
         errors++;
         $display("FAIL rst_cnts got=%0d/%0d/%0d exp=0",
                  o_err_cnt, o_tx_cnt, o_rx_cnt);
      end
      checks++;
      if ({uio.uio_rq_vld, uio.uio_rs_afull} !== 2'b0) begin
         errors++;
         $display("FAIL rst_uio got=%b exp=00",
                  {uio.uio_rq_vld, uio.uio_rs_afull});
      end
      reset_per = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_idle got=%b%b exp=00", o_busy, o_done);
      end
   endtask

   task automatic test_loopback();
      int cyc;
      start_run(1000);
      wait_done(3000, cyc);
      checks++;
      if (cyc != 1006) begin
         errors++;
         $display("FAIL lb_latency got=%0d exp=1006", cyc);
      end
      checks++;
      if (o_tx_cnt !== 32'd1000 || o_rx_cnt !== 32'd1000) begin
         errors++;
         $display("FAIL lb_cnt got=%0d/%0d exp=1000/1000",
                  o_tx_cnt, o_rx_cnt);
      end
      checks++;
      if (o_err_cnt !== 32'd0 || o_pass !== 1'b1 || o_timeout !== 1'b0) begin
         errors++;
         $display("FAIL lb_pass got=err%0d p%b t%b exp=err0 p1 t0",
                  o_err_cnt, o_pass, o_timeout);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL lb_sb_left got=%0d exp=0", exp_q.size());
      end
      repeat (8) @(negedge clk);
      checks++;
      if (o_rx_cnt !== 32'd1000 || o_done !== 1'b1) begin
         errors++;
         $display("FAIL lb_hold got=%0d/%b exp=1000/1", o_rx_cnt, o_done);
      end
   endtask

   task automatic test_zero();
      int cyc;
      int v0;
      v0 = vld_seen;
      start_run(0);
      wait_done(20, cyc);
      checks++;
      if (cyc != 1 || o_pass !== 1'b1) begin
         errors++;
         $display("FAIL zero_done got=cyc%0d p%b exp=cyc1 p1", cyc, o_pass);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (vld_seen != v0 || o_tx_cnt !== 32'd0) begin
         errors++;
         $display("FAIL zero_novld got=%0d/%0d exp=0/0",
                  vld_seen - v0, o_tx_cnt);
      end
   endtask

   task automatic test_afull();
      int cyc;
      afull_viol = 0;
      afull_run = 1'b1;
      fork
         begin
            while (afull_run) begin
               uio.uio_rq_afull = 1'b1;
               repeat (3) @(negedge clk);
               uio.uio_rq_afull = 1'b0;
               repeat (5) @(negedge clk);
            end
         end
      join_none
      start_run(1000);
      wait_done(5000, cyc);
      afull_run = 1'b0;
      repeat (12) @(negedge clk);
      uio.uio_rq_afull = 1'b0;
      checks++;
      if (afull_viol != 0) begin
         errors++;
         $display("FAIL afull_hold got=%0d exp=0", afull_viol);
      end
      checks++;
      if (o_rx_cnt !== 32'd1000 || o_err_cnt !== 32'd0 || o_pass !== 1'b1) begin
         errors++;
         $display("FAIL afull_pass got=rx%0d e%0d p%b exp=rx1000 e0 p1",
                  o_rx_cnt, o_err_cnt, o_pass);
      end
      checks++;
      if (cyc <= 1006) begin
         errors++;
         $display("FAIL afull_slow got=%0d exp=>1006", cyc);
      end
   endtask

   task automatic test_errors();
      int cyc;
      flip_a = 10;
      flip_b = 500;
      start_run(1000);
      wait_done(3000, cyc);
      flip_a = -1;
      flip_b = -1;
      checks++;
      if (o_err_cnt !== 32'd2 || o_pass !== 1'b0) begin
         errors++;
         $display("FAIL err_cnt got=e%0d p%b exp=e2 p0", o_err_cnt, o_pass);
      end
      checks++;
      if (o_rx_cnt !== 32'd1000 || o_timeout !== 1'b0) begin
         errors++;
         $display("FAIL err_rx got=%0d/%b exp=1000/0", o_rx_cnt, o_timeout);
      end
   endtask

   task automatic test_timeout();
      int cyc;
      int gap;
      drop_from = 997;
      start_run(1000);
      wait_done(3000, cyc);
      gap = edge_cnt - last_rx_edge;
      drop_from = 1 << 30;
      checks++;
      if (gap != TO) begin
         errors++;
         $display("FAIL to_gap got=%0d exp=%0d", gap, TO);
      end
      checks++;
      if (o_timeout !== 1'b1 || o_pass !== 1'b0) begin
         errors++;
         $display("FAIL to_flags got=t%b p%b exp=t1 p0", o_timeout, o_pass);
      end
      checks++;
      if (o_rx_cnt !== 32'd997 || o_tx_cnt !== 32'd1000) begin
         errors++;
         $display("FAIL to_cnt got=%0d/%0d exp=997/1000", o_rx_cnt, o_tx_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int n;
      logic [31:0] exp_lo;
      start_run(1000);
      n = 0;
      while (o_tx_cnt !== 32'd300 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (o_tx_cnt !== 32'd300) begin
         errors++;
         $display("FAIL rm_reach got=%0d exp=300", o_tx_cnt);
      end
      reset_per = 1'b1;
      @(posedge clk);
      #1 reset_per = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if ({o_busy, o_done, o_pass, o_timeout, uio.uio_rq_vld} !== 5'b0
          || {o_tx_cnt, o_rx_cnt, o_err_cnt} !== 96'd0) begin
         errors++;
         $display("FAIL rm_clear got=%b %0d/%0d/%0d exp=0",
                  {o_busy, o_done, o_pass, o_timeout, uio.uio_rq_vld},
                  o_tx_cnt, o_rx_cnt, o_err_cnt);
      end
      repeat (10) @(negedge clk);
      exp_lo = 32'h7000_0000;
`ifdef UIO_PRBS_ERR_INJECT_EN
      i_inject_err = 1'b1;
      @(negedge clk);
      i_inject_err = 1'b0;
      inj_pending = 1'b1;
      exp_lo = 32'h7000_0001;
`endif
      start_run(50);
      cyc = 0;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (uio.uio_rq_vld === 1'b1) break;
      end
      checks++;
      if (cyc != 2) begin
         errors++;
         $display("FAIL rm_latency got=%0d exp=2", cyc);
      end
      checks++;
      if (uio.uio_rq_data[31:0] !== exp_lo) begin
         errors++;
         $display("FAIL rm_seed_word got=%h exp=%h",
                  uio.uio_rq_data[31:0], exp_lo);
      end
      wait_done(500, cyc);
      checks++;
      if (o_tx_cnt !== 32'd50 || o_rx_cnt !== 32'd50) begin
         errors++;
         $display("FAIL rm_cnt got=%0d/%0d exp=50/50", o_tx_cnt, o_rx_cnt);
      end
`ifdef UIO_PRBS_ERR_INJECT_EN
      checks++;
      if (o_err_cnt !== 32'd1 || o_pass !== 1'b0) begin
         errors++;
         $display("FAIL rm_inj got=e%0d p%b exp=e1 p0", o_err_cnt, o_pass);
      end
`else
      checks++;
      if (o_err_cnt !== 32'd0 || o_pass !== 1'b1) begin
         errors++;
         $display("FAIL rm_pass got=e%0d p%b exp=e0 p1", o_err_cnt, o_pass);
      end
`endif
   endtask

   initial begin
      fork
         forever begin : mon
            logic [W-1:0] e;
            @(negedge clk);
            if (uio.uio_rq_vld === 1'b1) begin
               vld_seen++;
               if (afull_prev === 1'b1) afull_viol++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rq_extra got=%h exp=none", uio.uio_rq_data);
               end else begin
                  e = exp_q.pop_front();
                  if (uio.uio_rq_data !== e) begin
                     errors++;
                     $display("FAIL rq_data got=%h exp=%h",
                              uio.uio_rq_data, e);
                  end
               end
            end
         end
      join_none
      test_reset();
      test_loopback();
      test_zero();
      test_afull();
      test_errors();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
